dma_engine: RTL

DMA_ENGINE -- requirements
Module: dma_engine

---
 rtl/dma_engine.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dma_engine.sv
// Single-channel DMA between the core data memory port and a PIM bank port.
// One 32-bit word per beat: memory read then PIM write, or PIM read then memory write.
module dma_engine #(
  parameter int XLEN   = 32,
  parameter int PIM_AW = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dma_en,
  input  logic [2:0]        i_dma_funct3,
  input  logic [3:0]        i_dma_sel_pim,
  input  logic [11:0]       i_dma_size,
  input  logic [XLEN-1:0]   i_dma_mem_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_req_dmem,
  input  logic              i_gnt_dmem,
  output logic [XLEN-1:0]   o_data_addr,
  input  logic [XLEN-1:0]   i_data_rd_data,
  output logic [XLEN-1:0]   o_data_wr_data,
  output logic [3:0]        o_data_size,
  output logic              o_data_read,
  output logic              o_data_write,
  output logic [3:0]        o_pim_sel,
  output logic [PIM_AW-1:0] o_pim_addr,
  output logic [XLEN-1:0]   o_pim_wr_data,
  output logic              o_pim_write,
  output logic              o_pim_read,
  input  logic [XLEN-1:0]   i_pim_rd_data
);

  typedef enum logic [2:0] {IDLE, M_REQ, P_WR, P_RD, M_WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [11:0]       size_q, size_d;
  logic [11:0]       beats_q, beats_d;
  logic              to_mem_q, to_mem_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [PIM_AW-1:0] pim_addr_q, pim_addr_d;
  logic [XLEN-1:0]   hold_q, hold_d;
  logic              fresh_q, fresh_d;
  logic              beat_done;
  logic [XLEN-1:0]   wr_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      size_q     <= '0;
      beats_q    <= '0;
      to_mem_q   <= 1'b0;
      addr_q     <= '0;
      pim_addr_q <= '0;
      hold_q     <= '0;
      fresh_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      size_q     <= size_d;
      beats_q    <= beats_d;
      to_mem_q   <= to_mem_d;
      addr_q     <= addr_d;
      pim_addr_q <= pim_addr_d;
      hold_q     <= hold_d;
      fresh_q    <= fresh_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    size_d         = size_q;
    beats_d        = beats_q;
    to_mem_d       = to_mem_q;
    addr_d         = addr_q;
    pim_addr_d     = pim_addr_q;
    hold_d         = hold_q;
    fresh_d        = fresh_q;
    beat_done      = 1'b0;
    wr_data        = fresh_q ? i_pim_rd_data : hold_q;
    o_busy         = (state_q != IDLE);
    o_done         = 1'b0;
    o_req_dmem     = 1'b0;
    o_data_addr    = '0;
    o_data_wr_data = '0;
    o_data_size    = 4'b0000;
    o_data_read    = 1'b0;
    o_data_write   = 1'b0;
    o_pim_sel      = 4'b0000;
    o_pim_addr     = '0;
    o_pim_wr_data  = '0;
    o_pim_write    = 1'b0;
    o_pim_read     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_dma_en) begin
          sel_d      = i_dma_sel_pim;
          size_d     = i_dma_size;
          to_mem_d   = (i_dma_funct3 == 3'b001);
          addr_d     = i_dma_mem_addr & ~XLEN'(3);
          pim_addr_d = '0;
          beats_d    = '0;
          if (i_dma_size == 12'd0 || i_dma_funct3[2:1] != 2'b00)
            state_d = DONE;
          else if (i_dma_funct3[0])
            state_d = P_RD;
          else
            state_d = M_REQ;
        end
      end
      M_REQ: begin
        o_req_dmem  = 1'b1;
        o_data_read = 1'b1;
        o_data_size = 4'b1111;
        o_data_addr = addr_q;
        if (i_gnt_dmem) state_d = P_WR;
      end
      P_WR: begin
        // Read data is only valid this cycle, so it is forwarded straight to the bank.
        o_pim_sel     = sel_q;
        o_pim_addr    = pim_addr_q;
        o_pim_write   = 1'b1;
        o_pim_wr_data = i_data_rd_data;
        hold_d        = i_data_rd_data;
        beat_done     = 1'b1;
      end
      P_RD: begin
        o_pim_sel  = sel_q;
        o_pim_addr = pim_addr_q;
        o_pim_read = 1'b1;
        fresh_d    = 1'b1;
        state_d    = M_WR;
      end
      M_WR: begin
        // First M_WR cycle sees the bank output live; later wait cycles replay the held copy.
        o_req_dmem     = 1'b1;
        o_data_write   = 1'b1;
        o_data_size    = 4'b1111;
        o_data_addr    = addr_q;
        o_data_wr_data = wr_data;
        hold_d         = wr_data;
        fresh_d        = 1'b0;
        beat_done      = i_gnt_dmem;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (beat_done) begin
      addr_d     = addr_q + XLEN'(4);
      pim_addr_d = pim_addr_q + PIM_AW'(1);
      beats_d    = beats_q + 12'd1;
      if (beats_q + 12'd1 == size_q)
        state_d = DONE;
      else
        state_d = to_mem_q ? P_RD : M_REQ;
    end
  end

endmodule
